// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address type and the hardwired-zero register index
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_wsel.sv
// regfile_wsel: picks the highest-indexed enabled write port matching one nonzero address
module regfile_wsel import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = $clog2(NREGS_DEF),
  parameter int NWRITE = 1,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]               addr,
  input  logic [NWRITE-1:0]           w_en,
  input  logic [NWRITE-1:0][AW-1:0]   w_addr,
  input  logic [NWRITE-1:0][XLEN-1:0] w_data,
  output logic                        hit,
  output logic [XLEN-1:0]             data
);
  // later ports overwrite earlier ones so the highest index wins
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int j = 0; j < NWRITE; j++) begin
      if (BYPASS != 0 && w_en[j] && w_addr[j] == addr && addr != AW'(REG_ZERO)) begin
        hit = 1'b1;
        data = w_data[j];
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered reads, write bypass and busy scoreboard
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREAD-1:0][AW-1:0]    r_addr,
  output logic [NREAD-1:0][XLEN-1:0]  r_data,
  output logic [NREAD-1:0]            r_busy,
  input  logic [NWRITE-1:0]           w_en,
  input  logic [NWRITE-1:0][AW-1:0]   w_addr,
  input  logic [NWRITE-1:0][XLEN-1:0] w_data,
  input  logic                        alloc_en,
  input  logic [AW-1:0]               alloc_addr
);
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] wd [NREGS];
  logic [XLEN-1:0] rd_nx [NREAD];
  logic [NREGS-1:0] busy, busy_nx, we;
  logic [NREAD-1:0] rb_nx;
  genvar g, p;
  for (g = 0; g < NREGS; g++) begin : g_wdec
    regfile_wsel #(.XLEN(XLEN), .AW(AW), .NWRITE(NWRITE), .BYPASS(1)) u_dec (
      .addr(AW'(g)), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .hit(we[g]), .data(wd[g])
    );
    assign busy_nx[g] = (alloc_en && alloc_addr == AW'(g) && alloc_addr != AW'(REG_ZERO)) ||
                        (busy[g] && !we[g]);
  end
  for (p = 0; p < NREAD; p++) begin : g_rd
    logic hit;
    logic [XLEN-1:0] bd;
    regfile_wsel #(.XLEN(XLEN), .AW(AW), .NWRITE(NWRITE), .BYPASS(BYPASS)) u_rd (
      .addr(r_addr[p]), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .hit(hit), .data(bd)
    );
    assign rd_nx[p] = hit ? bd : regs[r_addr[p]];
    assign rb_nx[p] = BYPASS != 0 ? busy_nx[r_addr[p]] : busy[r_addr[p]];
  end
  // storage and scoreboard; register 0 is never written so it stays zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) if (we[r]) regs[r] <= wd[r];
      busy <= busy_nx;
    end
  end
  // registered read ports
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREAD; i++) r_data[i] <= rd_nx[i];
      r_busy <= rb_nx;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives a bypassing and a non-bypassing instance in lockstep against a reference model
module tb_regfile_mp;
  import regfile_pkg::*;
  localparam int NR = 4;
  localparam int NW = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  reg_addr_t [NR-1:0] r_addr;
  logic [NR-1:0][31:0] rd1, rd0;
  logic [NR-1:0] rb1, rb0;
  logic [NW-1:0] w_en;
  reg_addr_t [NW-1:0] w_addr;
  logic [NW-1:0][31:0] w_data;
  logic alloc_en;
  reg_addr_t alloc_addr;
  logic [31:0] mreg [32];
  logic mbus [32];
  int errors = 0;
  int checks = 0;

  regfile_mp #(.NREAD(NR), .NWRITE(NW), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .r_addr(r_addr), .r_data(rd1), .r_busy(rb1),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );
  regfile_mp #(.NREAD(NR), .NWRITE(NW), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .r_addr(r_addr), .r_data(rd0), .r_busy(rb0),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      mreg[r] = '0;
      mbus[r] = 1'b0;
    end
  endtask

  task automatic idle();
    w_en = '0;
    w_addr = '0;
    w_data = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    r_addr = '0;
  endtask

  // one clock: model predicts both instances from current inputs, then outputs are compared
  task automatic cyc(input string tag);
    logic [31:0] nreg [32];
    logic nb [32];
    logic [31:0] e1d [NR];
    logic [31:0] e0d [NR];
    logic e1b [NR];
    logic e0b [NR];
    nreg = mreg;
    nb = mbus;
    for (int j = 0; j < NW; j++) begin
      if (w_en[j] && w_addr[j] != REG_ZERO) begin
        nreg[w_addr[j]] = w_data[j];
        nb[w_addr[j]] = 1'b0;
      end
    end
    if (alloc_en && alloc_addr != REG_ZERO) nb[alloc_addr] = 1'b1;
    for (int i = 0; i < NR; i++) begin
      e1d[i] = nreg[r_addr[i]];
      e1b[i] = nb[r_addr[i]];
      e0d[i] = mreg[r_addr[i]];
      e0b[i] = mbus[r_addr[i]];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (rd1[i] !== e1d[i]) begin
        errors++;
        $display("FAIL %s byp1 r_data[%0d]: got %h want %h", tag, i, rd1[i], e1d[i]);
      end
      checks++;
      if (rb1[i] !== e1b[i]) begin
        errors++;
        $display("FAIL %s byp1 r_busy[%0d]: got %b want %b", tag, i, rb1[i], e1b[i]);
      end
      checks++;
      if (rd0[i] !== e0d[i]) begin
        errors++;
        $display("FAIL %s byp0 r_data[%0d]: got %h want %h", tag, i, rd0[i], e0d[i]);
      end
      checks++;
      if (rb0[i] !== e0b[i]) begin
        errors++;
        $display("FAIL %s byp0 r_busy[%0d]: got %b want %b", tag, i, rb0[i], e0b[i]);
      end
    end
    mreg = nreg;
    mbus = nb;
  endtask

  task automatic test_reset();
    idle();
    model_clear();
    #2;
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (rd1[i] !== '0 || rb1[i] !== 1'b0 || rd0[i] !== '0 || rb0[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_init port%0d: got %h/%b %h/%b want 0", i, rd1[i], rb1[i], rd0[i], rb0[i]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int r = 1; r < 32; r++) begin
      w_en = 3'b001;
      w_addr[0] = reg_addr_t'(r);
      w_data[0] = 32'(r);
      alloc_en = r[0];
      alloc_addr = reg_addr_t'(r);
      for (int i = 0; i < NR; i++) r_addr[i] = reg_addr_t'(r - i);
      cyc("fill");
    end
    w_en = 3'b001;
    w_addr[0] = 5'd5;
    w_data[0] = 32'h55;
    alloc_en = 1'b1;
    alloc_addr = 5'd5;
    r_addr = {5'd30, 5'd31, 5'd1, 5'd5};
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (rd1[i] !== '0 || rb1[i] !== 1'b0 || rd0[i] !== '0 || rb0[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_async port%0d: got %h/%b %h/%b want 0", i, rd1[i], rb1[i], rd0[i], rb0[i]);
      end
    end
    @(posedge clk);
    #1;
    idle();
    r_addr = {5'd30, 5'd31, 5'd1, 5'd5};
    reset = 1'b0;
    cyc("post_reset");
    checks++;
    if (rd1[0] !== 32'h0) begin
      errors++;
      $display("FAIL post_reset reg5: got %h want 0", rd1[0]);
    end
  endtask

  task automatic test_zero();
    idle();
    w_en = '1;
    for (int j = 0; j < NW; j++) w_data[j] = 32'hDEADBEEF;
    alloc_en = 1'b1;
    cyc("zero_wr");
    idle();
    cyc("zero_rd");
    checks++;
    if (rd1[0] !== 32'h0 || rb1[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg: got %h/%b want 0/0", rd1[0], rb1[0]);
    end
  endtask

  task automatic test_bypass();
    idle();
    w_en = 3'b001;
    w_addr[0] = 5'd7;
    w_data[0] = 32'h1111;
    cyc("byp_old");
    w_data[0] = 32'h1234;
    r_addr = {NR{5'd7}};
    cyc("byp_new");
    checks++;
    if (rd1[0] !== 32'h1234 || rd0[0] !== 32'h1111) begin
      errors++;
      $display("FAIL bypass_same: got %h/%h want 00001234/00001111", rd1[0], rd0[0]);
    end
    idle();
    r_addr = {NR{5'd7}};
    cyc("byp_next");
    checks++;
    if (rd0[0] !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_next: got %h want 00001234", rd0[0]);
    end
  endtask

  task automatic test_priority();
    idle();
    w_en = 3'b011;
    w_addr = {5'd3, 5'd3, 5'd3};
    w_data = {32'hC, 32'hB, 32'hA};
    r_addr = {NR{5'd3}};
    cyc("prio2");
    checks++;
    if (rd1[0] !== 32'hB) begin
      errors++;
      $display("FAIL prio_two: got %h want 0000000b", rd1[0]);
    end
    w_en = 3'b111;
    w_data = {32'hF, 32'hE, 32'hD};
    cyc("prio3");
    idle();
    r_addr = {NR{5'd3}};
    cyc("prio_rd");
    checks++;
    if (rd0[0] !== 32'hF) begin
      errors++;
      $display("FAIL prio_three: got %h want 0000000f", rd0[0]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    r_addr = {NR{5'd9}};
    alloc_en = 1'b1;
    alloc_addr = 5'd9;
    cyc("sb_alloc");
    checks++;
    if (rb1[0] !== 1'b1 || rb0[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_alloc: got %b/%b want 1/0", rb1[0], rb0[0]);
    end
    alloc_en = 1'b0;
    w_en = 3'b100;
    w_addr[2] = 5'd9;
    w_data[2] = 32'h99;
    cyc("sb_write");
    checks++;
    if (rb1[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear: got %b want 0", rb1[0]);
    end
    alloc_en = 1'b1;
    cyc("sb_both");
    checks++;
    if (rb1[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_alloc_wins: got %b want 1", rb1[0]);
    end
    idle();
    r_addr = {NR{5'd9}};
    cyc("sb_hold");
    checks++;
    if (rb0[0] !== 1'b1 || rd0[0] !== 32'h99) begin
      errors++;
      $display("FAIL sb_hold: got %b/%h want 1/00000099", rb0[0], rd0[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      w_en = NW'($urandom);
      for (int j = 0; j < NW; j++) begin
        w_addr[j] = $urandom_range(0, 1) ? reg_addr_t'($urandom_range(0, 7)) : reg_addr_t'($urandom);
        w_data[j] = $urandom;
      end
      alloc_en = 1'($urandom);
      alloc_addr = reg_addr_t'($urandom_range(0, 7));
      for (int i = 0; i < NR; i++)
        r_addr[i] = $urandom_range(0, 1) ? reg_addr_t'($urandom_range(0, 7)) : reg_addr_t'($urandom);
      cyc("rand");
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_bypass();
    test_priority();
    test_scoreboard();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
